// File: rtl/pipeline_run_controller.sv
// Run/step/halt sequencer for the pipeline: owns the global enable, the ID flush,
// the post-HALT drain and an executed-cycle counter for the debug unit.
module pipeline_run_controller #(
    parameter int unsigned NB_CYCLES    = 32,
    parameter int unsigned DRAIN_CYCLES = 3,
    parameter int unsigned NB_DRAIN     = 3
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_run,
    input  logic                 i_step,
    input  logic                 i_abort,
    input  logic                 i_halt_decoded,
    output logic                 o_enable,
    output logic                 o_flush,
    output logic                 o_busy,
    output logic                 o_halted,
    output logic [2:0]           o_state,
    output logic [NB_CYCLES-1:0] o_cycle_count
);

    typedef enum logic [2:0] {
        StIdle   = 3'b000,
        StRun    = 3'b001,
        StStep   = 3'b010,
        StDrain  = 3'b011,
        StHalted = 3'b100
    } state_e;

    // Drain length minus one: the counter reaches zero in the last drain cycle.
    localparam logic [NB_DRAIN-1:0] DrainLoad = NB_DRAIN'(DRAIN_CYCLES - 1);

    state_e               state_q, state_d;
    logic [NB_DRAIN-1:0]  drain_q, drain_d;
    logic [NB_CYCLES-1:0] count_q, count_d;

    // State, drain counter and cycle counter registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= StIdle;
            drain_q <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
            count_q <= count_d;
        end
    end

    // Next-state and drain counter; abort overrides every state.
    always_comb begin
        state_d = state_q;
        drain_d = drain_q;
        unique case (state_q)
            StIdle: begin
                if (i_run) begin
                    state_d = StRun;
                end else if (i_step) begin
                    state_d = StStep;
                end
            end
            StRun: begin
                if (i_halt_decoded) begin
                    state_d = StDrain;
                    drain_d = DrainLoad;
                end
            end
            StStep: begin
                if (i_halt_decoded) begin
                    state_d = StDrain;
                    drain_d = DrainLoad;
                end else begin
                    state_d = StIdle;
                end
            end
            StDrain: begin
                if (drain_q == '0) begin
                    state_d = StHalted;
                end else begin
                    drain_d = drain_q - NB_DRAIN'(1);
                end
            end
            StHalted: state_d = StHalted;
            default: begin
                state_d = StIdle;
                drain_d = '0;
            end
        endcase
        if (i_abort) begin
            state_d = StIdle;
            drain_d = '0;
        end
    end

    // Cycle counter: cleared on an accepted run, saturating count of enabled cycles.
    always_comb begin
        count_d = count_q;
        if (state_q == StIdle && i_run && !i_abort) begin
            count_d = '0;
        end else if (o_enable && count_q != '1) begin
            count_d = count_q + NB_CYCLES'(1);
        end
    end

    // Moore outputs decoded from the registered state only.
    always_comb begin
        o_enable = 1'b0;
        o_flush  = 1'b0;
        o_busy   = 1'b0;
        o_halted = 1'b0;
        unique case (state_q)
            StRun, StStep: begin
                o_enable = 1'b1;
                o_busy   = 1'b1;
            end
            StDrain: begin
                o_enable = 1'b1;
                o_flush  = 1'b1;
                o_busy   = 1'b1;
            end
            StHalted: o_halted = 1'b1;
            default: ;
        endcase
    end

    assign o_state       = state_q;
    assign o_cycle_count = count_q;

endmodule

// File: tb/tb_pipeline_run_controller.sv
// Scoreboard bench for pipeline_run_controller: a cycle-indexed reference model pushes
// expected outputs per edge, a monitor pops and compares. A second instance with a
// 4-bit counter shares the stimulus to exercise saturation.
module tb_pipeline_run_controller;

    localparam int DRAIN = 3;
    localparam int M_IDLE = 0, M_RUN = 1, M_STEP = 2, M_DRAIN = 3, M_HALTED = 4;
    localparam longint MAX32 = 64'h0000_0000_FFFF_FFFF;

    typedef struct packed {
        logic [2:0]  st;
        logic        en;
        logic        fl;
        logic        bz;
        logic        hl;
        logic [31:0] c32;
        logic [2:0]  st4;
        logic [3:0]  c4;
    } obs_t;

    logic clk = 1'b0, rst_n = 1'b0;
    logic run = 1'b0, step = 1'b0, abort = 1'b0, halt = 1'b0;

    logic        en_a, fl_a, bz_a, hl_a;
    logic [2:0]  st_a;
    logic [31:0] cnt_a;
    logic        en_b, fl_b, bz_b, hl_b;
    logic [2:0]  st_b;
    logic [3:0]  cnt_b;

    int total = 0;
    int bad   = 0;
    obs_t exp_q[$];

    // Reference model: mode code, absolute cycle index, end cycle of the current drain.
    int     mode;
    longint t;
    longint drain_end;
    longint c32;
    int     c4;

    pipeline_run_controller #(.NB_CYCLES(32), .DRAIN_CYCLES(DRAIN), .NB_DRAIN(3)) dut32 (
        .i_clk(clk), .i_rst_n(rst_n), .i_run(run), .i_step(step), .i_abort(abort),
        .i_halt_decoded(halt), .o_enable(en_a), .o_flush(fl_a), .o_busy(bz_a),
        .o_halted(hl_a), .o_state(st_a), .o_cycle_count(cnt_a)
    );

    pipeline_run_controller #(.NB_CYCLES(4), .DRAIN_CYCLES(DRAIN), .NB_DRAIN(3)) dut4 (
        .i_clk(clk), .i_rst_n(rst_n), .i_run(run), .i_step(step), .i_abort(abort),
        .i_halt_decoded(halt), .o_enable(en_b), .o_flush(fl_b), .o_busy(bz_b),
        .o_halted(hl_b), .o_state(st_b), .o_cycle_count(cnt_b)
    );

    always #5 clk = ~clk;

    function automatic obs_t actual();
        obs_t o;
        o.st = st_a; o.en = en_a; o.fl = fl_a; o.bz = bz_a; o.hl = hl_a;
        o.c32 = cnt_a; o.st4 = st_b; o.c4 = cnt_b;
        return o;
    endfunction

    function automatic obs_t model_obs();
        obs_t o;
        bit active = (mode == M_RUN) || (mode == M_STEP) || (mode == M_DRAIN);
        o.st  = 3'(mode);
        o.en  = active;
        o.fl  = (mode == M_DRAIN);
        o.bz  = active;
        o.hl  = (mode == M_HALTED);
        o.c32 = 32'(c32);
        o.st4 = 3'(mode);
        o.c4  = 4'(c4);
        return o;
    endfunction

    task automatic model_reset();
        mode = M_IDLE; t = 0; drain_end = 0; c32 = 0; c4 = 0;
    endtask

    // One clock edge of the specified behaviour, given the inputs present this cycle.
    task automatic model_step(input logic r, input logic s, input logic a, input logic h);
        bit active = (mode == M_RUN) || (mode == M_STEP) || (mode == M_DRAIN);
        int nxt = mode;
        if (mode == M_IDLE && r && !a) begin
            c32 = 0;
            c4  = 0;
        end else if (active) begin
            if (c32 < MAX32) c32 = c32 + 1;
            if (c4 < 15) c4 = c4 + 1;
        end
        case (mode)
            M_IDLE: if (r) nxt = M_RUN; else if (s) nxt = M_STEP;
            M_RUN, M_STEP: begin
                if (h) begin
                    nxt = M_DRAIN;
                    drain_end = t + DRAIN;
                end else if (mode == M_STEP) begin
                    nxt = M_IDLE;
                end
            end
            M_DRAIN: if (t == drain_end) nxt = M_HALTED;
            default: ;
        endcase
        if (a) nxt = M_IDLE;
        mode = nxt;
        t = t + 1;
    endtask

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", name, got, want);
        end
    endtask

    // Drive one cycle of inputs and queue the outputs expected after the next edge.
    task automatic cycle(input logic r, input logic s, input logic a, input logic h);
        @(negedge clk);
        rst_n = 1'b1; run = r; step = s; abort = a; halt = h;
        model_step(r, s, a, h);
        exp_q.push_back(model_obs());
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; run = 1'b0; step = 1'b0; abort = 1'b0; halt = 1'b0;
        #1;
        check("reset_outputs_zero", 64'(actual()), 64'(0));
        model_reset();
        exp_q.push_back(model_obs());
    endtask

    // Wait until the edge for the last queued cycle has been applied.
    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    // Monitor: every edge with a pending expectation is compared.
    initial begin : monitor
        obs_t e, a;
        int idx = 0;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = actual();
                total++;
                if (a !== e) begin
                    bad++;
                    $display("FAIL scoreboard[%0d]: got st=%b en=%b fl=%b bz=%b hl=%b c32=%0d st4=%b c4=%0d want st=%b en=%b fl=%b bz=%b hl=%b c32=%0d st4=%b c4=%0d",
                             idx, a.st, a.en, a.fl, a.bz, a.hl, a.c32, a.st4, a.c4,
                             e.st, e.en, e.fl, e.bz, e.hl, e.c32, e.st4, e.c4);
                end
                idx++;
            end
        end
    end

    initial begin : stimulus
        model_reset();

        // Run, halt after 10 cycles, drain, park.
        do_reset();
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        idle(10);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        idle(5);
        settle();
        check("run_halt_state", 64'(st_a), 64'(4));
        check("run_halt_count", 64'(cnt_a), 64'(14));
        check("run_halt_enable", 64'(en_a), 64'(0));
        // Run/step while halted are ignored.
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        settle();
        check("halted_ignores_run", 64'(st_a), 64'(4));

        // Three separated steps.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b1, 1'b0, 1'b0);
            idle(2);
        end
        settle();
        check("step_count", 64'(cnt_a), 64'(3));
        check("step_back_idle", 64'(st_a), 64'(0));

        // Step into a HALT decode.
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        idle(4);
        settle();
        check("step_halt_halted", 64'(hl_a), 64'(1));

        // Abort in the second drain cycle, then a fresh run restarts the count.
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        idle(1);
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        settle();
        check("abort_drain_state", 64'(st_a), 64'(0));
        check("abort_drain_flush", 64'(fl_a), 64'(0));
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        settle();
        check("rerun_count_zero", 64'(cnt_a), 64'(0));

        // Run and step together, then asynchronous reset mid-run.
        do_reset();
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        settle();
        check("run_beats_step", 64'(st_a), 64'(1));
        rst_n = 1'b0; run = 1'b0; step = 1'b0;
        #1;
        check("async_reset_zero", 64'(actual()), 64'(0));
        model_reset();
        @(negedge clk);
        exp_q.push_back(model_obs());

        // Long run saturates the narrow counter.
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        idle(20);
        settle();
        check("narrow_saturate", 64'(cnt_b), 64'(15));
        idle(3);
        settle();
        check("narrow_stays", 64'(cnt_b), 64'(15));

        // Randomized traffic against the model.
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0),
                  ($urandom_range(0, 39) == 0), ($urandom_range(0, 7) == 0));
        end

        repeat (2) @(posedge clk);
        #2;
        check("queue_drained", 64'(exp_q.size()), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
